// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-file write port among writeback sources.
// Optional grant locking is compiled in with `define RF_ARB_LOCK_EN.
module rf_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [3*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rf_write_en,
    output logic [2:0]             rf_write_addr,
    output logic [7:0]             rf_in,
    output logic                   busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [PW-1:0] rr_ptr, rr_idx, gnt_idx;
    logic          rr_any, gnt_any;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Highest offset first so the nearest requester at or after rr_ptr wins.
    always_comb begin
        rr_any = 1'b0;
        rr_idx = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(32'(rr_ptr) + k) % NUM_REQ]) begin
                rr_any = 1'b1;
                rr_idx = PW'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

`ifdef RF_ARB_LOCK_EN
    logic [PW-1:0] owner;
    logic [CW-1:0] lock_cnt;

    always_comb begin
        gnt_any = ~rst & ~stall & (busy ? req[owner] : rr_any);
        gnt_idx = busy ? owner : rr_idx;
    end

    // A lock survives stalls; it ends on an unlocked grant, an idle owner or the grant limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            lock_cnt <= '0;
        end else if (busy) begin
            if (!stall) begin
                if (gnt_any && req_lock[owner] && lock_cnt != CW'(MAX_LOCK - 1)) begin
                    lock_cnt <= lock_cnt + 1'b1;
                end else begin
                    busy     <= 1'b0;
                    lock_cnt <= '0;
                    rr_ptr   <= inc(owner);
                end
            end
        end else if (gnt_any) begin
            rr_ptr <= inc(gnt_idx);
            if (req_lock[gnt_idx] && MAX_LOCK > 1) begin
                busy     <= 1'b1;
                owner    <= gnt_idx;
                lock_cnt <= CW'(1);
            end
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^{req_lock, CW'(MAX_LOCK)};
    assign busy        = 1'b0;

    always_comb begin
        gnt_any = ~rst & ~stall & rr_any;
        gnt_idx = rr_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= inc(gnt_idx);
    end
`endif

    assign gnt = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_in         <= '0;
        end else begin
            rf_write_en <= gnt_any;
            if (gnt_any) begin
                rf_write_addr <= req_addr[3*gnt_idx +: 3];
                rf_in         <= req_data[8*gnt_idx +: 8];
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed-vector bench for rf_write_arbiter (NUM_REQ=3, MAX_LOCK=4).
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst, stall;
    logic [2:0]  req, req_lock, gnt;
    logic [8:0]  req_addr;
    logic [23:0] req_data;
    logic        rf_write_en, busy;
    logic [2:0]  rf_write_addr;
    logic [7:0]  rf_in;
    int n_cmp = 0;
    int n_err = 0;

    rf_write_arbiter #(.NUM_REQ(3), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .req(req), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_in(rf_in), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; req = '0; req_lock = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[3*i +: 3] = a;
        req_data[8*i +: 8] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; req = 3'b111; req_lock = '0;
        set_src(0, 3'd1, 8'h10); set_src(1, 3'd2, 8'h21); set_src(2, 3'd5, 8'h32);
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_cmp++; if ({rf_write_en, rf_write_addr, rf_in} !== 12'h000) begin n_err++;
            $display("FAIL reset_rf: got en=%b addr=%0d data=%h want 0/0/00", rf_write_en, rf_write_addr, rf_in); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_src(1, 3'd3, 8'h5A); req = 3'b010;
        #1;
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b want 010", gnt); end
        tick();
        req = 3'b000;
        n_cmp++; if ({rf_write_en, rf_write_addr, rf_in} !== {1'b1, 3'd3, 8'h5A}) begin n_err++;
            $display("FAIL single_write: got en=%b addr=%0d data=%h want 1/3/5a", rf_write_en, rf_write_addr, rf_in); end
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL single_idle_gnt: got %b want 000", gnt); end
        tick();
        n_cmp++; if (rf_write_en !== 1'b0 || rf_in !== 8'h5A) begin n_err++;
            $display("FAIL single_hold: got en=%b data=%h want 0/5a", rf_write_en, rf_in); end
        req = 3'b111;
        #1;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL single_rrptr: got %b want 100", gnt); end
        req = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [7:0] exp_d [6] = '{8'h10, 8'h21, 8'h32, 8'h10, 8'h21, 8'h32};
        logic [2:0] exp_a [6] = '{3'd1, 3'd2, 3'd5, 3'd1, 3'd2, 3'd5};
        do_reset();
        set_src(0, 3'd1, 8'h10); set_src(1, 3'd2, 8'h21); set_src(2, 3'd5, 8'h32);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (gnt !== exp_g[k]) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g[k]); end
            tick();
            n_cmp++; if ({rf_write_en, rf_write_addr, rf_in} !== {1'b1, exp_a[k], exp_d[k]}) begin n_err++;
                $display("FAIL rr_write[%0d]: got en=%b addr=%0d data=%h want 1/%0d/%h", k, rf_write_en, rf_write_addr, rf_in, exp_a[k], exp_d[k]); end
        end
        req = 3'b000;
        tick();
        n_cmp++; if (rf_write_en !== 1'b0) begin n_err++; $display("FAIL rr_end_en: got %b want 0", rf_write_en); end
    endtask

    task automatic test_stall();
        do_reset();
        set_src(0, 3'd1, 8'h10); set_src(2, 3'd5, 8'h32);
        req = 3'b101; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL stall_gnt[%0d]: got %b want 000", k, gnt); end
            tick();
            n_cmp++; if (rf_write_en !== 1'b0) begin n_err++; $display("FAIL stall_en[%0d]: got %b want 0", k, rf_write_en); end
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL stall_rel0: got %b want 001", gnt); end
        tick();
        req = 3'b100;
        n_cmp++; if (rf_write_en !== 1'b1 || rf_in !== 8'h10) begin n_err++;
            $display("FAIL stall_w0: got en=%b data=%h want 1/10", rf_write_en, rf_in); end
        #1;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL stall_rel2: got %b want 100", gnt); end
        tick();
        stall = 1'b1;
        #1;
        n_cmp++; if (gnt !== 3'b000 || rf_write_en !== 1'b1 || rf_in !== 8'h32) begin n_err++;
            $display("FAIL stall_keep_write: got gnt=%b en=%b data=%h want 000/1/32", gnt, rf_write_en, rf_in); end
        stall = 1'b0; req = 3'b000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_src(2, 3'd5, 8'h32);
        req = 3'b100;
        #1;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL rmid_gnt: got %b want 100", gnt); end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if ({rf_write_en, rf_write_addr, rf_in} !== 12'h000 || gnt !== 3'b000) begin n_err++;
            $display("FAIL rmid_drop: got en=%b addr=%0d data=%h gnt=%b want 0/0/00/000", rf_write_en, rf_write_addr, rf_in, gnt); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL rmid_regrant: got %b want 100", gnt); end
        tick();
        n_cmp++; if ({rf_write_en, rf_write_addr, rf_in} !== {1'b1, 3'd5, 8'h32}) begin n_err++;
            $display("FAIL rmid_write: got en=%b addr=%0d data=%h want 1/5/32", rf_write_en, rf_write_addr, rf_in); end
        req = 3'b000;
    endtask

    task automatic test_lock();
`ifdef RF_ARB_LOCK_EN
        logic [2:0] exp_g [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
        logic       exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int         exp_busy_cnt = 4;
`else
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        logic       exp_b [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int         exp_busy_cnt = 0;
`endif
        int busy_cnt = 0;
        do_reset();
        set_src(0, 3'd1, 8'h10); set_src(1, 3'd2, 8'h21);
        req = 3'b011; req_lock = 3'b001;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (gnt !== exp_g[k]) begin n_err++; $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, exp_g[k]); end
            tick();
            if (busy === 1'b1) busy_cnt++;
            n_cmp++; if (busy !== exp_b[k]) begin n_err++; $display("FAIL lock_busy[%0d]: got %b want %b", k, busy, exp_b[k]); end
        end
        n_cmp++; if (busy_cnt !== exp_busy_cnt) begin n_err++; $display("FAIL lock_busy_cycles: got %0d want %0d", busy_cnt, exp_busy_cnt); end
        req = 3'b000; req_lock = 3'b000;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; req = '0; req_lock = '0; req_addr = '0; req_data = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (`rf_write_en`, `rf_write_addr`, `rf_in`) among several writeback sources: ALU result, memory load return and the VGA/peripheral status path. Each cycle it grants at most one requester with round-robin fairness. It registers the winning address and data into the port, and supports a core-side stall that blocks all grants. It sits between the CPU writeback sources and `reg_file`.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, legal range 2..8.
- `MAX_LOCK`, default 4: maximum consecutive grants to one locked requester, legal range 1..15.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: reset. One clock; reset is asynchronous and active-high.
- `stall` input, 1 bit: when high, no grant is issued this cycle.
- `req` input, `NUM_REQ` bits: request per source.
- `req_lock` input, `NUM_REQ` bits: the source asks to keep the port on its next request. Only used with the macro (see Configuration).
- `req_addr` input, `3*NUM_REQ` bits: destination register. Source i uses bits `[3i+2:3i]`.
- `req_data` input, `8*NUM_REQ` bits: write data. Source i uses bits `[8i+7:8i]`.
- `gnt` output, `NUM_REQ` bits: one-hot or zero. Combinational, valid in the same cycle as the request.
- `rf_write_en` output, 1 bit: registered write enable to `reg_file`.
- `rf_write_addr` output, 3 bits: registered write address.
- `rf_in` output, 8 bits: registered write data.
- `busy` output, 1 bit: registered; high while a lock is held.

## Operation
Request handshake:
- A source raises `req[i]` and holds `req`, `req_addr` and `req_data` stable until it samples `gnt[i]=1` at a rising edge.
- After that edge the source may drop `req` or present its next write.

Grant selection:
- Round-robin pointer `rr_ptr`, range 0..NUM_REQ-1, reset value 0.
- The grant goes to the first requesting source scanning from `rr_ptr` upward, wrapping modulo NUM_REQ.
- After a grant to source i, `rr_ptr <= (i+1) mod NUM_REQ`.
- With `stall=1`: `gnt=0` and `rr_ptr` holds.
- With no `req` asserted: `gnt=0` and `rr_ptr` holds.

Output register, on a rising edge:
- If any `gnt` bit is set: `rf_write_en<=1`, and `rf_write_addr` and `rf_in` take the granted source's fields.
- Otherwise: `rf_write_en<=0`, and `rf_write_addr` and `rf_in` hold their previous values.

Other rules:
- A source that drops `req` before being granted loses nothing; no state is kept per request.
- Two sources targeting the same register are serialized in grant order. The later write wins.

Reset:
- Reset values: `gnt=0`, `rf_write_en=0`, `rf_write_addr=0`, `rf_in=0`, `busy=0`, `rr_ptr=0`, lock owner cleared, lock count 0.
- Reset asserted mid-operation discards any registered write not yet committed. A source still holding `req` is re-arbitrated after reset deasserts.

## Timing
- Latency: `req[i]` granted in cycle N, `rf_write_en=1` during cycle N+1, register updated at the end of cycle N+1. Load-to-use latency is 2 cycles.
- Throughput: one write per cycle, sustained.
- `stall` is sampled combinationally and affects the grant in the same cycle. It never cancels a write already registered.
- No combinational path from `req` or `stall` to the `rf_*` outputs.

## Configuration
With `RF_ARB_LOCK_EN` defined:
- If source i is granted with `req_lock[i]=1`, the arbiter records i as lock owner: `busy<=1`, lock count <= 1.
- While locked and not stalled, only the owner can be granted. Other requests wait.
- Each locked grant increments the count.
- The lock releases (`busy<=0`, `rr_ptr<=(owner+1) mod NUM_REQ`) on any of:
  - a grant with `req_lock=0`;
  - an idle cycle of the owner (`req` low and not stalled);
  - count reaching `MAX_LOCK`.
- A stall does not release the lock.

Without the macro:
- `req_lock` is ignored and `busy` is tied to 0.
- Pure round-robin.

## Test plan
- Reset, then source 1 requests addr 3, data 0x5A: `gnt=3'b010` that cycle; next cycle `rf_write_en=1`, addr 3, `rf_in=0x5A`; `rr_ptr=2`.
- All three sources request continuously for 6 cycles from reset: grant order 0,1,2,0,1,2; `rf_write_en` high for 6 consecutive cycles, starting one cycle after the first grant.
- `stall=1` for 2 cycles with sources 0 and 2 requesting: `gnt=0` and `rf_write_en=0` one cycle later. After release, source 0 is granted, then source 2.
- Reset asserted in the cycle after a grant to source 2: `rf_write_en` drops to 0 immediately and no write occurs. After release, source 2 (still requesting) is granted first.
- `RF_ARB_LOCK_EN`, `MAX_LOCK=4`: source 0 requests with lock for 6 cycles while source 1 requests. Grants go 0,0,0,0,1,0; `busy` is high for 4 cycles.
- Macro undefined: same stimulus as the previous scenario gives grants 0,1,0,1,0,1 and `busy` stays 0.
